// File: rtl/mario_pkg.sv
// Shared screen geometry, motion-state encoding and sprite ids for the Mario motion stage.
package mario_pkg;

   localparam int SCREEN_W = 1280;
   localparam int SCREEN_H = 896;
   localparam int SPRITE_W = 64;
   localparam int SPRITE_H = 128;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } motion_state_e;

   localparam logic [5:0] ID_STAND_R  = 6'd1;
   localparam logic [5:0] ID_WALK_R_0 = 6'd2;
   localparam logic [5:0] ID_JUMP_R   = 6'd5;
   localparam logic [5:0] ID_STAND_L  = 6'd6;
   localparam logic [5:0] ID_WALK_L_0 = 6'd7;
   localparam logic [5:0] ID_JUMP_L   = 6'd10;

   function automatic logic [5:0] sprite_id(
      input motion_state_e st,
      input logic          face_l,
      input logic          walk,
      input logic [1:0]    anim
   );
      logic [5:0] id;
      if (st != ST_GROUND) begin
         id = face_l ? ID_JUMP_L : ID_JUMP_R;
      end else if (walk) begin
         id = (face_l ? ID_WALK_L_0 : ID_WALK_R_0) + {4'd0, anim};
      end else begin
         id = face_l ? ID_STAND_L : ID_STAND_R;
      end
      return id;
   endfunction

endpackage

// File: rtl/mario_motion_btn_sync.sv
// Two-flop button synchroniser with a rising-edge detect whose history only advances on frame ticks.
module btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic btn_i,
   output logic lvl_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         if (tick_i) begin
            prev_q <= sync_q;
         end
      end
   end

   assign lvl_o  = sync_q;
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mario_motion.sv
// Per-frame Mario position / sprite-id update with walk, jump and gravity.
// Build option MARIO_VARJUMP_EN: releasing jump while rising caps the upward speed for short hops.
module mario_motion
   import mario_pkg::*;
#(
   parameter int X_MIN      = 0,
   parameter int X_MAX      = SCREEN_W - SPRITE_W,
   parameter int X_INIT     = 64,
   parameter int GROUND_Y   = SCREEN_H - SPRITE_H,
   parameter int WALK_SPEED = 4,
   parameter int JUMP_V0    = 20,
   parameter int GRAVITY    = 1,
   parameter int VY_MAX     = 16,
   parameter int ANIM_DIV   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   output logic [10:0] mario_x,
   output logic [9:0]  mario_y,
   output logic [5:0]  mario_id
);

   // state   | meaning
   // GROUND  | standing or walking at GROUND_Y, jump edge launches
   // RISE    | moving up, speed decays by GRAVITY each frame
   // FALL    | moving down, speed grows to VY_MAX, lands at GROUND_Y

   localparam logic [5:0] VARJUMP_CAP = 6'd4;

   logic left_lvl, right_lvl, jump_lvl, jump_rise;
   logic unused_rise_left, unused_rise_right;

   btn_sync u_sync_left (
      .clk    (clk),
      .rst    (rst),
      .tick_i (frame_tick),
      .btn_i  (btn_left),
      .lvl_o  (left_lvl),
      .rise_o (unused_rise_left)
   );

   btn_sync u_sync_right (
      .clk    (clk),
      .rst    (rst),
      .tick_i (frame_tick),
      .btn_i  (btn_right),
      .lvl_o  (right_lvl),
      .rise_o (unused_rise_right)
   );

   btn_sync u_sync_jump (
      .clk    (clk),
      .rst    (rst),
      .tick_i (frame_tick),
      .btn_i  (btn_jump),
      .lvl_o  (jump_lvl),
      .rise_o (jump_rise)
   );

`ifndef MARIO_VARJUMP_EN
   logic unused_jump_lvl;
   assign unused_jump_lvl = jump_lvl;
`endif

   motion_state_e state_q, state_d;
   logic [10:0]   x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic [5:0]    vy_q, vy_d;
   logic          face_l_q, face_l_d;
   logic [1:0]    anim_q, anim_d;
   logic [2:0]    div_q, div_d;
   logic [5:0]    id_q, id_d;

   logic          move_l, move_r, walking;
   logic [5:0]    vy_eff, vy_fall;
   logic [6:0]    vy_sum;
   logic [10:0]   y_ext, y_rise, y_fall;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vy_d     = vy_q;
      face_l_d = face_l_q;
      anim_d   = anim_q;
      div_d    = div_q;
      id_d     = id_q;
      move_l   = left_lvl & ~right_lvl;
      move_r   = right_lvl & ~left_lvl;
      walking  = 1'b0;
      vy_eff   = vy_q;
      vy_sum   = {1'b0, vy_q} + 7'(GRAVITY);
      vy_fall  = (vy_sum > 7'(VY_MAX)) ? 6'(VY_MAX) : vy_sum[5:0];
      y_ext    = {1'b0, y_q};
      y_rise   = '0;
      y_fall   = y_ext + {5'd0, vy_fall};

      if (frame_tick) begin
         if (move_l) begin
            x_d      = (x_q < 11'(X_MIN + WALK_SPEED)) ? 11'(X_MIN) : x_q - 11'(WALK_SPEED);
            face_l_d = 1'b1;
         end else if (move_r) begin
            x_d      = (x_q > 11'(X_MAX - WALK_SPEED)) ? 11'(X_MAX) : x_q + 11'(WALK_SPEED);
            face_l_d = 1'b0;
         end

         case (state_q)
            ST_GROUND: begin
               if (jump_rise) begin
                  vy_d    = 6'(JUMP_V0);
                  state_d = ST_RISE;
               end
            end
            ST_RISE: begin
`ifdef MARIO_VARJUMP_EN
               if (!jump_lvl && (vy_q > VARJUMP_CAP)) begin
                  vy_eff = VARJUMP_CAP;
               end
`endif
               y_rise = y_ext - {5'd0, vy_eff};
               // the 11-bit difference exposes a climb past the top edge before it wraps
               if (y_ext < {5'd0, vy_eff}) begin
                  y_d     = '0;
                  vy_d    = '0;
                  state_d = ST_FALL;
               end else begin
                  y_d = y_rise[9:0];
                  if (vy_eff <= 6'(GRAVITY)) begin
                     vy_d    = '0;
                     state_d = ST_FALL;
                  end else begin
                     vy_d = vy_eff - 6'(GRAVITY);
                  end
               end
            end
            ST_FALL: begin
               if (y_fall >= 11'(GROUND_Y)) begin
                  y_d     = 10'(GROUND_Y);
                  vy_d    = '0;
                  state_d = ST_GROUND;
               end else begin
                  y_d  = y_fall[9:0];
                  vy_d = vy_fall;
               end
            end
            default: begin
               y_d     = 10'(GROUND_Y);
               vy_d    = '0;
               state_d = ST_GROUND;
            end
         endcase

         walking = (state_d == ST_GROUND) && (move_l || move_r);
         if (walking) begin
            if (div_q == 3'd0) begin
               div_d  = 3'(ANIM_DIV - 1);
               anim_d = (anim_q == 2'd2) ? 2'd0 : anim_q + 2'd1;
            end else begin
               div_d = div_q - 3'd1;
            end
         end else begin
            div_d  = 3'(ANIM_DIV - 1);
            anim_d = 2'd0;
         end

         id_d = sprite_id(state_d, face_l_d, walking, anim_d);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_GROUND;
         x_q      <= 11'(X_INIT);
         y_q      <= 10'(GROUND_Y);
         vy_q     <= '0;
         face_l_q <= 1'b0;
         anim_q   <= 2'd0;
         div_q    <= 3'(ANIM_DIV - 1);
         id_q     <= ID_STAND_R;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vy_q     <= vy_d;
         face_l_q <= face_l_d;
         anim_q   <= anim_d;
         div_q    <= div_d;
         id_q     <= id_d;
      end
   end

   assign mario_x  = x_q;
   assign mario_y  = y_q;
   assign mario_id = id_q;

endmodule

// File: doc/mario_motion.md
Name: mario_motion

Overview:
- Player-motion stage directly upstream of the VGA renderer.
- Converts button inputs into Mario's screen position (top-left corner) and sprite id once per video frame, using a small walk/jump/fall state machine with gravity.
- Outputs feed the renderer's mario_x / mario_y / mario_id inputs and are held stable between frame updates.

Parameters:
- X_MIN, 0, leftmost allowed mario_x
- X_MAX, 1216, rightmost allowed mario_x (1280 − 64 sprite width)
- X_INIT, 64, mario_x after reset
- GROUND_Y, 768, mario_y when standing (896 − 128)
- WALK_SPEED, 4, pixels per frame horizontally
- JUMP_V0, 20, initial upward speed, pixels/frame
- GRAVITY, 1, speed change per frame
- VY_MAX, 16, terminal fall speed
- ANIM_DIV, 6, frames per walk-animation step

Ports:
- clk  in  1  pixel clock, same domain as the renderer
- rst  in  1  asynchronous reset, active-low
- frame_tick  in  1  one-cycle pulse per frame (vertical-blank start)
- btn_left  in  1  asynchronous button, active-high
- btn_right  in  1  asynchronous button, active-high
- btn_jump  in  1  asynchronous button, active-high
- mario_x  out  11  sprite top-left x, pixels
- mario_y  out  10  sprite top-left y, pixels
- mario_id  out  6  sprite id for the Object lookup

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst. All state clears immediately on rst=0, including mid-jump.
- Reset values:
  - mario_x = X_INIT
  - mario_y = GROUND_Y
  - mario_id = ID_STAND_R
  - state = GROUND, vy = 0, facing = right, anim = 0, jump_prev = 0
- Input synchronisation:
  - Each button passes through a 2-flop synchroniser.
  - Logic uses only the synchronised values, sampled in the frame_tick cycle.
- Update timing:
  - All state updates happen only in the cycle where frame_tick = 1.
  - Outputs are registered and change on the clock edge that samples frame_tick (latency 1 cycle).
  - Outputs hold between ticks.
- Horizontal movement:
  - left only: x −= WALK_SPEED, saturating at X_MIN; facing = left.
  - right only: x += WALK_SPEED, saturating at X_MAX; facing = right.
  - both or neither: x and facing unchanged.
  - Saturation never wraps.
- States: GROUND, RISE, FALL. vy is unsigned 6-bit speed magnitude.
  - GROUND: if jump rises (jump=1 and jump_prev=0), set vy = JUMP_V0 and go to RISE. Otherwise stay.
  - RISE: y −= vy, then vy −= GRAVITY. When the new vy = 0, go to FALL.
  - FALL: vy = min(vy + GRAVITY, VY_MAX), then y += vy.
  - Landing: if y + vy ≥ GROUND_Y, set y = GROUND_Y, vy = 0, go to GROUND.
- Jump edge detection:
  - jump_prev updates on every tick.
  - Holding jump never re-triggers on landing.
  - Jump presses in RISE or FALL are ignored.
- Sprite id selection:
  - GROUND, moving: walk frame ID_WALK_{R|L}_0 + anim.
  - GROUND, not moving: ID_STAND_{R|L}.
  - RISE or FALL: ID_JUMP_{R|L}.
- Walk animation:
  - A divider counts ticks while walking on ground.
  - Every ANIM_DIV ticks, anim advances 0→1→2→0.
  - Divider and anim clear when not walking or airborne.
- Width rules:
  - y arithmetic is done in 11 bits to avoid underflow.
  - mario_y is never below 0: a RISE result < 0 clamps to 0 and forces FALL.

Optional Feature:
- Macro: MARIO_VARJUMP_EN.
- Defined: in RISE, if jump is 0 on a tick, vy is clamped to min(vy, 4) before the update. Short taps give low jumps.
- Undefined: jump height is fixed by JUMP_V0 regardless of release.

Decomposition:
- Package mario_pkg holds:
  - state enum (GROUND/RISE/FALL)
  - sprite-id constants: ID_STAND_R=1, ID_WALK_R_0=2..4, ID_JUMP_R=5, ID_STAND_L=6, ID_WALK_L_0=7..9, ID_JUMP_L=10
  - screen constants shared with the renderer
- Natural sub-module: btn_sync (2-flop synchroniser plus tick-sampled edge detect), instantiated per button.

Test Plan:
- Reset with rst=0 mid-stream, then release -> mario_x=64, mario_y=768, mario_id=1 immediately and on the first tick.
- Hold right for 10 ticks -> mario_x=104; mario_id goes 2 (ticks 1–5), 3 (ticks 6–10). Release -> mario_id=1 on the next tick.
- Pulse jump on one tick, no horizontal input:
  - mario_y sequence 748, 729, 711, …; apex 558 on tick 20; mario_id=5 throughout.
  - Lands at 768 on tick 21 of the fall; mario_id returns to 1.
- Start at x=1212 and hold right -> 1216, then stays 1216. Hold left from 2 -> 0, then stays 0.
- Hold left and right together for 5 ticks -> x unchanged, mario_id=stand, facing unchanged.
- Hold jump continuously through landing -> no second jump. A jump press during FALL is ignored.
- Additional test with MARIO_VARJUMP_EN defined: release jump on RISE tick 3 -> vy clamps to 4; apex y = 768 − (20+19+18+4+3+2+1) = 701.
